// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the regfile_sb register file.
// No logic here; no latency or backpressure.
package regfile_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_bypass.sv
// Read mux with writeback bypass: lane 1 beats lane 0 beats stored value; address 0 reads zero.
// Purely combinational (0 cycles); no flow control.
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic              w0_en,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    input  logic              w1_en,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    input  logic [DATA_W-1:0] stored,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = '0;
        if (en && (addr != '0)) begin
            if (w1_en && (w1_addr == addr)) begin
                data = w1_data;
            end else if (w0_en && (w0_addr == addr)) begin
                data = w0_data;
            end else begin
                data = stored;
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// 2R/2W register file with bypass, busy scoreboard and post-reset clear; optional debug port under REGFILE_DBG_EN.
// Reads 0-cycle, writes 1-cycle; no backpressure, ready low for NREGS-1 cycles after reset.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] op1_o,
    output logic [DATA_W-1:0] op2_o,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              alloc_en,
    input  logic [ADDR_W-1:0] alloc_addr,
    input  logic              w0_en,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    input  logic              w1_en,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data
`ifdef REGFILE_DBG_EN
    ,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [15:0]       wr_cnt
`endif
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_idx;
    logic              run;
    logic              w0_ok;
    logic              w1_ok;
    logic              fwd1;
    logic              fwd2;
    logic [NREGS-1:0]  busy;
    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (clr_idx == LAST_IDX) state_nxt = ST_RUN;
            ST_RUN:   state_nxt = ST_RUN;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    assign run   = (state == ST_RUN);
    assign ready = run;

    // Writes to r0 are dropped here so neither storage nor scoreboard sees them.
    assign w0_ok = run && w0_en && (w0_addr != '0);
    assign w1_ok = run && w1_en && (w1_addr != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            clr_idx <= ADDR_W'(1);
        end else if (!run) begin
            clr_idx <= clr_idx + 1'b1;
        end
    end

    // Lane 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (!run) begin
                regs[clr_idx] <= '0;
            end else begin
                if (w0_ok) regs[w0_addr] <= w0_data;
                if (w1_ok) regs[w1_addr] <= w1_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= '0;
        end else if (run) begin
            for (int i = 1; i < NREGS; i++) begin
                if ((w0_ok && (w0_addr == ADDR_W'(i))) || (w1_ok && (w1_addr == ADDR_W'(i)))) begin
                    busy[i] <= 1'b0;
                end
                // A fresh allocation outranks a retiring older producer.
                if (alloc_en && (alloc_addr == ADDR_W'(i))) begin
                    busy[i] <= 1'b1;
                end
            end
        end
    end

    assign fwd1 = (w0_ok && (w0_addr == rs1_addr)) || (w1_ok && (w1_addr == rs1_addr));
    assign fwd2 = (w0_ok && (w0_addr == rs2_addr)) || (w1_ok && (w1_addr == rs2_addr));

    assign rs1_busy = run && busy[rs1_addr] && !fwd1;
    assign rs2_busy = run && busy[rs2_addr] && !fwd2;

    regfile_bypass #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_byp1 (
        .en      (run),
        .addr    (rs1_addr),
        .w0_en   (w0_en),
        .w0_addr (w0_addr),
        .w0_data (w0_data),
        .w1_en   (w1_en),
        .w1_addr (w1_addr),
        .w1_data (w1_data),
        .stored  (regs[rs1_addr]),
        .data    (op1_o)
    );

    regfile_bypass #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_byp2 (
        .en      (run),
        .addr    (rs2_addr),
        .w0_en   (w0_en),
        .w0_addr (w0_addr),
        .w0_data (w0_data),
        .w1_en   (w1_en),
        .w1_addr (w1_addr),
        .w1_data (w1_data),
        .stored  (regs[rs2_addr]),
        .data    (op2_o)
    );

`ifdef REGFILE_DBG_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            dbg_data <= '0;
            wr_cnt   <= '0;
        end else begin
            dbg_data <= (dbg_addr == '0) ? '0 : regs[dbg_addr];
            wr_cnt   <= wr_cnt + 16'(w0_ok) + 16'(w1_ok);
        end
    end
`endif

endmodule
